// File: rtl/hazard_pool_controller_if.sv
// Hazard pool controller bus: pool geometry, player boxes and player status.
// With HAZARD_GRACE_EN defined the bus also carries grace_active.
interface hazard_pool_controller_if #(
    parameter int unsigned POOL_COUNT = 4
);
    logic                      frame_tick;
    logic                      restart;
    logic [POOL_COUNT*16-1:0]  pool_x;
    logic [POOL_COUNT*16-1:0]  pool_y;
    logic [POOL_COUNT*2-1:0]   pool_type;
    logic [15:0]               p1_top, p1_bottom, p1_left, p1_right;
    logic [15:0]               p2_top, p2_bottom, p2_left, p2_right;
    logic [1:0]                p1_state, p2_state;
    logic                      p1_dead, p2_dead;
    logic [3:0]                p1_pool, p2_pool;
    logic                      game_over;
`ifdef HAZARD_GRACE_EN
    logic                      grace_active;
`endif

    modport master (
        output frame_tick, restart, pool_x, pool_y, pool_type,
        output p1_top, p1_bottom, p1_left, p1_right,
        output p2_top, p2_bottom, p2_left, p2_right,
`ifdef HAZARD_GRACE_EN
        input  grace_active,
`endif
        input  p1_state, p2_state, p1_dead, p2_dead, p1_pool, p2_pool, game_over
    );

    modport slave (
        input  frame_tick, restart, pool_x, pool_y, pool_type,
        input  p1_top, p1_bottom, p1_left, p1_right,
        input  p2_top, p2_bottom, p2_left, p2_right,
`ifdef HAZARD_GRACE_EN
        output grace_active,
`endif
        output p1_state, p2_state, p1_dead, p2_dead, p1_pool, p2_pool, game_over
    );
endinterface

// File: rtl/hazard_pool_controller.sv
// Hazard pool controller: detects player/pool overlaps, runs a per-player
// ALIVE -> DYING -> DEAD sequence and reports the pool that caused death.
// Optional feature macro HAZARD_GRACE_EN: hits are ignored for 60 frame
// ticks after reset release or restart, flagged on grace_active.
module hazard_pool_controller #(
    parameter int unsigned POOL_COUNT   = 4,
    parameter int unsigned POOL_W       = 80,
    parameter int unsigned POOL_H       = 12,
    parameter int unsigned DYING_FRAMES = 30
) (
    input logic                       Clk,
    input logic                       Reset_n,
    hazard_pool_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        StAlive = 2'd0,
        StDying = 2'd1,
        StDead  = 2'd2
    } state_e;

    localparam logic signed [16:0] PoolW = 17'(POOL_W);
    localparam logic signed [16:0] PoolH = 17'(POOL_H);

    // Index 0 is player 1 (fire), index 1 is player 2 (ice).
    logic [1:0][POOL_COUNT-1:0] hit_d, hit_q;
    state_e                     state_q [2];
    logic [7:0]                 cnt_q   [2];
    logic [3:0]                 pool_q  [2];

    // Edges that merely touch do not count as overlap.
    function automatic logic box_hit(input logic [15:0] l, input logic [15:0] r,
                                     input logic [15:0] t, input logic [15:0] b,
                                     input logic [15:0] x, input logic [15:0] y);
        logic signed [16:0] ls, rs, ts, bs, xs, ys;
        ls = $signed({l[15], l});
        rs = $signed({r[15], r});
        ts = $signed({t[15], t});
        bs = $signed({b[15], b});
        xs = $signed({x[15], x});
        ys = $signed({y[15], y});
        return (rs > xs) && (ls < xs + PoolW) && (bs > ys) && (ts < ys + PoolH);
    endfunction

    function automatic logic [3:0] lowest_index(input logic [POOL_COUNT-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = int'(POOL_COUNT) - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

`ifdef HAZARD_GRACE_EN
    logic [5:0] grace_q;

    // Grace window: reloaded on reset and restart, counts down on frame ticks.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grace_q <= 6'd60;
        end else if (bus.restart) begin
            grace_q <= 6'd60;
        end else if (bus.frame_tick && (grace_q != 6'd0)) begin
            grace_q <= grace_q - 6'd1;
        end
    end

    assign bus.grace_active = (grace_q != 6'd0);
`endif

    // Per-pool overlap filtered by which player each pool type kills.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < int'(POOL_COUNT); i++) begin
            // FIRE kills p2, WATER kills p1, GOO kills both, DISABLED nobody.
            if ((bus.pool_type[2*i +: 2] == 2'd1 || bus.pool_type[2*i +: 2] == 2'd2) &&
                box_hit(bus.p1_left, bus.p1_right, bus.p1_top, bus.p1_bottom,
                        bus.pool_x[16*i +: 16], bus.pool_y[16*i +: 16])) begin
                hit_d[0][i] = 1'b1;
            end
            if ((bus.pool_type[2*i +: 2] == 2'd0 || bus.pool_type[2*i +: 2] == 2'd2) &&
                box_hit(bus.p2_left, bus.p2_right, bus.p2_top, bus.p2_bottom,
                        bus.pool_x[16*i +: 16], bus.pool_y[16*i +: 16])) begin
                hit_d[1][i] = 1'b1;
            end
        end
`ifdef HAZARD_GRACE_EN
        if (grace_q != 6'd0) hit_d = '0;
`endif
    end

    // Hit pipeline stage; restart flushes it so a stale hit cannot kill.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q <= '0;
        end else if (bus.restart) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    // Per-player life FSM with dying frame counter and latched killer pool.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= StAlive;
                cnt_q[p]   <= '0;
                pool_q[p]  <= '0;
            end
        end else if (bus.restart) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= StAlive;
                cnt_q[p]   <= '0;
                pool_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                unique case (state_q[p])
                    StAlive: begin
                        if (|hit_q[p]) begin
                            state_q[p] <= StDying;
                            cnt_q[p]   <= 8'(DYING_FRAMES);
                            pool_q[p]  <= lowest_index(hit_q[p]);
                        end
                    end
                    StDying: begin
                        if (bus.frame_tick) begin
                            if (cnt_q[p] == 8'd1) begin
                                state_q[p] <= StDead;
                                cnt_q[p]   <= '0;
                            end else begin
                                cnt_q[p] <= cnt_q[p] - 8'd1;
                            end
                        end
                    end
                    StDead: begin
                        state_q[p] <= StDead;
                    end
                    default: begin
                        state_q[p] <= StAlive;
                    end
                endcase
            end
        end
    end

    assign bus.p1_state  = state_q[0];
    assign bus.p2_state  = state_q[1];
    assign bus.p1_dead   = (state_q[0] != StAlive);
    assign bus.p2_dead   = (state_q[1] != StAlive);
    assign bus.p1_pool   = pool_q[0];
    assign bus.p2_pool   = pool_q[1];
    assign bus.game_over = (state_q[0] == StDead) || (state_q[1] == StDead);

endmodule

// File: tb/tb_hazard_pool_controller.sv
// Directed self-checking bench for hazard_pool_controller (DYING_FRAMES = 3).
module tb_hazard_pool_controller;

    logic Clk;
    logic Reset_n;
    int   n_checks;
    int   n_fail;

    hazard_pool_controller_if #(.POOL_COUNT(4)) bus ();

    hazard_pool_controller #(
        .POOL_COUNT   (4),
        .POOL_W       (80),
        .POOL_H       (12),
        .DYING_FRAMES (3)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_pool(input int i, input int x, input int y, input logic [1:0] t);
        bus.pool_x[16*i +: 16]   = 16'(x);
        bus.pool_y[16*i +: 16]   = 16'(y);
        bus.pool_type[2*i +: 2]  = t;
    endtask

    task automatic set_p1(input int l, input int r, input int t, input int b);
        bus.p1_left = 16'(l); bus.p1_right = 16'(r); bus.p1_top = 16'(t); bus.p1_bottom = 16'(b);
    endtask

    task automatic set_p2(input int l, input int r, input int t, input int b);
        bus.p2_left = 16'(l); bus.p2_right = 16'(r); bus.p2_top = 16'(t); bus.p2_bottom = 16'(b);
    endtask

    task automatic idle_inputs();
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        for (int i = 0; i < 4; i++) set_pool(i, 0, 0, 2'd3);
        set_p1(2000, 2010, 2000, 2010);
        set_p2(3000, 3010, 3000, 3010);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic clear_grace();
`ifdef HAZARD_GRACE_EN
        repeat (60) tick();
`endif
    endtask

    task automatic do_restart();
        idle_inputs();
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
        clear_grace();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        cyc(2);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL reset_p1_state: got %0d want 0", bus.p1_state); end
        n_checks++; if (bus.p2_state !== 2'd0) begin n_fail++; $display("FAIL reset_p2_state: got %0d want 0", bus.p2_state); end
        n_checks++; if (bus.p1_dead !== 1'b0) begin n_fail++; $display("FAIL reset_p1_dead: got %0b want 0", bus.p1_dead); end
        n_checks++; if (bus.p2_dead !== 1'b0) begin n_fail++; $display("FAIL reset_p2_dead: got %0b want 0", bus.p2_dead); end
        n_checks++; if (bus.p1_pool !== 4'd0) begin n_fail++; $display("FAIL reset_p1_pool: got %0d want 0", bus.p1_pool); end
        n_checks++; if (bus.p2_pool !== 4'd0) begin n_fail++; $display("FAIL reset_p2_pool: got %0d want 0", bus.p2_pool); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0b want 0", bus.game_over); end
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(1);
    endtask

`ifdef HAZARD_GRACE_EN
    task automatic test_grace();
        n_checks++; if (bus.grace_active !== 1'b1) begin n_fail++; $display("FAIL grace_active_on: got %0b want 1", bus.grace_active); end
        set_pool(0, 296, 463, 2'd1);
        set_p1(300, 320, 450, 470);
        cyc(3);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL grace_hit_ignored: got %0d want 0", bus.p1_state); end
        idle_inputs();
        clear_grace();
        n_checks++; if (bus.grace_active !== 1'b0) begin n_fail++; $display("FAIL grace_active_off: got %0b want 0", bus.grace_active); end
    endtask
`endif

    task automatic test_hit_water();
        set_pool(0, 296, 463, 2'd1);
        set_p1(300, 320, 450, 470);
        cyc(1);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL water_latency1: got %0d want 0", bus.p1_state); end
        cyc(1);
        n_checks++; if (bus.p1_state !== 2'd1) begin n_fail++; $display("FAIL water_p1_state: got %0d want 1", bus.p1_state); end
        n_checks++; if (bus.p1_dead !== 1'b1) begin n_fail++; $display("FAIL water_p1_dead: got %0b want 1", bus.p1_dead); end
        n_checks++; if (bus.p1_pool !== 4'd0) begin n_fail++; $display("FAIL water_p1_pool: got %0d want 0", bus.p1_pool); end
        n_checks++; if (bus.p2_state !== 2'd0) begin n_fail++; $display("FAIL water_p2_state: got %0d want 0", bus.p2_state); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL water_game_over: got %0b want 0", bus.game_over); end
        do_restart();
    endtask

    task automatic test_edge_touch();
        set_pool(0, 296, 463, 2'd1);
        set_p1(276, 296, 450, 470);
        cyc(3);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL edge_right_touch: got %0d want 0", bus.p1_state); end
        set_p1(376, 396, 450, 470);
        cyc(3);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL edge_left_touch: got %0d want 0", bus.p1_state); end
        set_p1(300, 320, 475, 490);
        cyc(3);
        n_checks++; if (bus.p1_dead !== 1'b0) begin n_fail++; $display("FAIL edge_top_touch: got %0b want 0", bus.p1_dead); end
        idle_inputs();
        cyc(2);
    endtask

    task automatic test_lowest_index();
        set_pool(1, 100, 100, 2'd1);
        set_pool(2, 100, 100, 2'd2);
        set_pool(3, 110, 100, 2'd0);
        set_p2(105, 130, 95, 105);
        cyc(2);
        n_checks++; if (bus.p2_state !== 2'd1) begin n_fail++; $display("FAIL lowest_p2_state: got %0d want 1", bus.p2_state); end
        n_checks++; if (bus.p2_pool !== 4'd2) begin n_fail++; $display("FAIL lowest_p2_pool: got %0d want 2", bus.p2_pool); end
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL lowest_p1_state: got %0d want 0", bus.p1_state); end
        set_pool(0, 100, 100, 2'd0);
        cyc(3);
        n_checks++; if (bus.p2_pool !== 4'd2) begin n_fail++; $display("FAIL pool_held_in_dying: got %0d want 2", bus.p2_pool); end
        n_checks++; if (bus.p2_state !== 2'd1) begin n_fail++; $display("FAIL hit_ignored_in_dying: got %0d want 1", bus.p2_state); end
        idle_inputs();
    endtask

    task automatic test_dying_to_dead();
        tick();
        n_checks++; if (bus.p2_state !== 2'd1) begin n_fail++; $display("FAIL tick1_state: got %0d want 1", bus.p2_state); end
        tick();
        n_checks++; if (bus.p2_state !== 2'd1) begin n_fail++; $display("FAIL tick2_state: got %0d want 1", bus.p2_state); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL tick2_game_over: got %0b want 0", bus.game_over); end
        tick();
        n_checks++; if (bus.p2_state !== 2'd2) begin n_fail++; $display("FAIL tick3_state: got %0d want 2", bus.p2_state); end
        n_checks++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL tick3_game_over: got %0b want 1", bus.game_over); end
        n_checks++; if (bus.p2_dead !== 1'b1) begin n_fail++; $display("FAIL tick3_p2_dead: got %0b want 1", bus.p2_dead); end
        tick();
        cyc(2);
        n_checks++; if (bus.p2_state !== 2'd2) begin n_fail++; $display("FAIL dead_hold: got %0d want 2", bus.p2_state); end
        n_checks++; if (bus.p2_pool !== 4'd2) begin n_fail++; $display("FAIL dead_pool_hold: got %0d want 2", bus.p2_pool); end
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL dead_p1_alive: got %0d want 0", bus.p1_state); end
    endtask

    task automatic test_restart_priority();
        set_pool(0, 296, 463, 2'd1);
        set_p1(300, 320, 450, 470);
        cyc(1);
        bus.restart    = 1'b1;
        bus.frame_tick = 1'b1;
        cyc(1);
        idle_inputs();
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL restart_p1_state: got %0d want 0", bus.p1_state); end
        n_checks++; if (bus.p2_state !== 2'd0) begin n_fail++; $display("FAIL restart_p2_state: got %0d want 0", bus.p2_state); end
        n_checks++; if (bus.p2_pool !== 4'd0) begin n_fail++; $display("FAIL restart_p2_pool: got %0d want 0", bus.p2_pool); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %0b want 0", bus.game_over); end
        n_checks++; if (bus.p2_dead !== 1'b0) begin n_fail++; $display("FAIL restart_p2_dead: got %0b want 0", bus.p2_dead); end
        cyc(2);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL restart_flush: got %0d want 0", bus.p1_state); end
        n_checks++; if (bus.p1_pool !== 4'd0) begin n_fail++; $display("FAIL restart_p1_pool: got %0d want 0", bus.p1_pool); end
        clear_grace();
    endtask

    task automatic test_back_to_back();
        set_pool(1, 500, 500, 2'd2);
        set_p1(510, 520, 505, 515);
        set_p2(530, 540, 505, 515);
        cyc(2);
        n_checks++; if (bus.p1_state !== 2'd1) begin n_fail++; $display("FAIL both_p1_state: got %0d want 1", bus.p1_state); end
        n_checks++; if (bus.p2_state !== 2'd1) begin n_fail++; $display("FAIL both_p2_state: got %0d want 1", bus.p2_state); end
        n_checks++; if (bus.p1_pool !== 4'd1) begin n_fail++; $display("FAIL both_p1_pool: got %0d want 1", bus.p1_pool); end
        n_checks++; if (bus.p2_pool !== 4'd1) begin n_fail++; $display("FAIL both_p2_pool: got %0d want 1", bus.p2_pool); end
        do_restart();
    endtask

    task automatic test_reset_mid_dying();
        set_pool(0, 296, 463, 2'd1);
        set_p1(300, 320, 450, 470);
        cyc(2);
        idle_inputs();
        tick();
        n_checks++; if (bus.p1_state !== 2'd1) begin n_fail++; $display("FAIL middying_pre: got %0d want 1", bus.p1_state); end
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL middying_async_state: got %0d want 0", bus.p1_state); end
        n_checks++; if (bus.p1_dead !== 1'b0) begin n_fail++; $display("FAIL middying_async_dead: got %0b want 0", bus.p1_dead); end
        cyc(1);
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(2);
        n_checks++; if (bus.p1_state !== 2'd0) begin n_fail++; $display("FAIL middying_after_release: got %0d want 0", bus.p1_state); end
`ifdef HAZARD_GRACE_EN
        n_checks++; if (bus.grace_active !== 1'b1) begin n_fail++; $display("FAIL middying_grace: got %0b want 1", bus.grace_active); end
`endif
        clear_grace();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
`ifdef HAZARD_GRACE_EN
        test_grace();
`endif
        test_hit_water();
        test_edge_touch();
        test_lowest_index();
        test_dying_to_dead();
        test_restart_priority();
        test_back_to_back();
        test_reset_mid_dying();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_pool_controller.md
HAZARD_POOL_CONTROLLER -- requirements
Module: hazard_pool_controller

Interface
REQ-001 SHALL have parameter POOL_COUNT, default 4, number of hazard pools (1..16).
REQ-002 SHALL have parameter POOL_W, default 80, pool width in pixels.
REQ-003 SHALL have parameter POOL_H, default 12, pool height in pixels.
REQ-004 SHALL have parameter DYING_FRAMES, default 30, frames spent in DYING before DEAD (1..255).
REQ-005 SHALL have port Clk, input, 1, system clock.
REQ-006 SHALL have port Reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-008 SHALL have port restart, input, 1, one-cycle pulse that returns both players to ALIVE.
REQ-009 SHALL have port pool_x, input, POOL_COUNT*16, signed left X per pool; pool i at bits [16i+15:16i].
REQ-010 SHALL have port pool_y, input, POOL_COUNT*16, signed top Y per pool; same packing as pool_x.
REQ-011 SHALL have port pool_type, input, POOL_COUNT*2, per-pool type: 0 FIRE, 1 WATER, 2 GOO, 3 DISABLED.
REQ-012 SHALL have ports p1_top, p1_bottom, p1_left, p1_right, input, 16 each, signed player-1 (fire) box.
REQ-013 SHALL have ports p2_top, p2_bottom, p2_left, p2_right, input, 16 each, signed player-2 (ice) box.
REQ-014 SHALL have ports p1_state, p2_state, output, 2 each: 0 ALIVE, 1 DYING, 2 DEAD.
REQ-015 SHALL have ports p1_dead, p2_dead, output, 1 each, high in DYING or DEAD.
REQ-016 SHALL have ports p1_pool, p2_pool, output, 4 each, index of the pool that caused death.
REQ-017 SHALL have port game_over, output, 1, high when either player is in DEAD.

Function
REQ-018 SHALL define a hit on pool i as right > x, left < x+POOL_W, bottom > y, top < y+POOL_H, all 17-bit signed; touching edges are not hits.
REQ-019 SHALL apply type masks: FIRE kills player 2 only, WATER kills player 1 only, GOO kills both, DISABLED kills neither.
REQ-020 SHALL register the per-player hit vectors (1 cycle), then update the FSM on the next edge; hit-to-DYING latency SHALL be 2 cycles.
REQ-021 SHALL, when several pools hit in the same cycle, capture the lowest index in pN_pool.
REQ-022 SHALL move ALIVE->DYING on a registered hit, load the frame counter with DYING_FRAMES, and latch pN_pool.
REQ-023 SHALL decrement the counter in DYING on each frame_tick, and move DYING->DEAD on the tick that takes it from 1 to 0.
REQ-024 SHALL hold DEAD, together with pN_pool, until restart or reset.
REQ-025 SHALL ignore hits in DYING and DEAD; pN_pool SHALL NOT change after the first capture.
REQ-026 SHALL give restart priority over a simultaneous hit or frame_tick: both FSMs go to ALIVE, counters and pN_pool clear to 0, and the hit pipeline flushes.
REQ-027 SHALL run the two players independently; both may change state in the same cycle.

Reset
REQ-028 SHALL, on Reset_n low, asynchronously clear: p1_state/p2_state = ALIVE, pN_dead = 0, pN_pool = 0, game_over = 0, counters = 0, hit registers = 0.
REQ-029 SHALL, if Reset_n asserts mid-DYING, abandon the sequence; after release the block starts in ALIVE.

Configuration
REQ-030 SHALL, with macro HAZARD_GRACE_EN defined, ignore all hits for 60 frame_ticks after reset release or restart, with output grace_active (1 bit) high during that window.
REQ-031 SHALL, with HAZARD_GRACE_EN undefined, omit grace_active and evaluate hits from the first cycle after reset.

Verification
REQ-032 SHALL cover: pool0 WATER at (296,463), p1 box L300 R320 T450 B470 -> p1_state DYING 2 cycles later, p1_pool=0, p2 ALIVE.
REQ-033 SHALL cover: p1 right=296 at pool x=296 (edge touch) -> no hit, p1 stays ALIVE.
REQ-034 SHALL cover: p2 overlapping GOO pool2 and FIRE pool3 in the same cycle -> p2_pool=2.
REQ-035 SHALL cover: DYING_FRAMES=3, then 3 frame_ticks -> DEAD on the 3rd tick, game_over=1.
REQ-036 SHALL cover: restart coincident with a new hit and a tick -> both ALIVE, pool indices 0, no DYING.
REQ-037 SHALL cover: Reset_n low during DYING (count 2) -> asynchronous return to ALIVE; with HAZARD_GRACE_EN, a hit within 60 ticks is ignored and grace_active=1.
